// File: rtl/rv_alu_core_mc.sv
// Multi-cycle RV32I/RV32E integer ALU core: fetches over a req/gnt/rvalid port,
// executes OP and (optionally) OP-IMM, and halts on ECALL or any illegal encoding.
module rv_alu_core_mc #(
  parameter int              XLEN     = 32,
  parameter int              NREGS    = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter bit              IMM_EN   = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] pc,
  output logic            retire,
  output logic [3:0]      flags,
  output logic            halt,
  output logic            illegal,
  input  logic [4:0]      dbg_raddr,
  output logic [XLEN-1:0] dbg_rdata
);

  localparam int AW = $clog2(NREGS);
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_ir;
  logic            r_req;
  logic            r_retire;
  logic [3:0]      r_flags;
  logic            r_halt;
  logic            r_illegal;
  logic [XLEN-1:0] r_regs [NREGS];

  logic            w_legal;
  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  logic [XLEN-1:0] w_imm;
  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_diff;
  logic [XLEN-1:0] w_result;
  logic            w_c;
  logic            w_v;
  logic            w_is_op;
  logic [2:0]      w_f3;

  function automatic logic idx_ok(input logic [4:0] idx);
    return ({27'd0, idx} < 32'(NREGS));
  endfunction

  function automatic logic insn_legal(input logic [31:0] insn);
    logic [6:0] opc;
    logic [6:0] f7;
    logic [2:0] f3;
    logic       regs_ok;
    logic       ok;
    opc     = insn[6:0];
    f7      = insn[31:25];
    f3      = insn[14:12];
    regs_ok = idx_ok(insn[11:7]) && idx_ok(insn[19:15]);
    ok      = 1'b0;
    case (opc)
      OPC_OP: begin
        ok = regs_ok && idx_ok(insn[24:20]) &&
             ((f7 == F7_ZERO) ||
              ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101))));
      end
      OPC_OP_IMM: begin
        if (IMM_EN) begin
          case (f3)
            3'b001:  ok = regs_ok && (f7 == F7_ZERO);
            3'b101:  ok = regs_ok && ((f7 == F7_ZERO) || (f7 == F7_ALT));
            default: ok = regs_ok;
          endcase
        end else begin
          ok = 1'b0;
        end
      end
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // x0 and indices beyond the implemented file always read as zero
  function automatic logic [XLEN-1:0] read_reg(input logic [4:0] idx);
    logic [XLEN-1:0] val;
    if ((idx == 5'd0) || !idx_ok(idx)) begin
      val = '0;
    end else begin
      val = r_regs[idx[AW-1:0]];
    end
    return val;
  endfunction

  assign w_legal = insn_legal(r_ir);
  assign w_is_op = (r_ir[6:0] == OPC_OP);
  assign w_f3    = r_ir[14:12];
  assign w_imm   = {{(XLEN-12){r_ir[31]}}, r_ir[31:20]};
  assign w_a     = read_reg(r_ir[19:15]);
  assign w_b     = w_is_op ? read_reg(r_ir[24:20]) : w_imm;

  // ALU datapath and flag generation for the instruction held in r_ir
  always_comb begin
    w_sum    = {1'b0, w_a} + {1'b0, w_b};
    w_diff   = {1'b0, w_a} - {1'b0, w_b};
    w_result = '0;
    w_c      = 1'b0;
    w_v      = 1'b0;
    case (w_f3)
      3'b000: begin
        if (w_is_op && r_ir[30]) begin
          w_result = w_diff[XLEN-1:0];
          w_c      = ~w_diff[XLEN];
          w_v      = (w_a[XLEN-1] != w_b[XLEN-1]) && (w_diff[XLEN-1] != w_a[XLEN-1]);
        end else begin
          w_result = w_sum[XLEN-1:0];
          w_c      = w_sum[XLEN];
          w_v      = (w_a[XLEN-1] == w_b[XLEN-1]) && (w_sum[XLEN-1] != w_a[XLEN-1]);
        end
      end
      3'b001: w_result = w_a << w_b[4:0];
      3'b010: w_result = {{(XLEN-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
      3'b011: w_result = {{(XLEN-1){1'b0}}, (w_a < w_b)};
      3'b100: w_result = w_a ^ w_b;
      3'b101: begin
        if (r_ir[30]) begin
          w_result = $signed(w_a) >>> w_b[4:0];
        end else begin
          w_result = w_a >> w_b[4:0];
        end
      end
      3'b110: w_result = w_a | w_b;
      3'b111: w_result = w_a & w_b;
      default: w_result = '0;
    endcase
  end

  // Control FSM, architectural state and registered status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_FETCH;
      r_pc      <= RESET_PC;
      r_ir      <= 32'd0;
      r_req     <= 1'b0;
      r_retire  <= 1'b0;
      r_flags   <= 4'd0;
      r_halt    <= 1'b0;
      r_illegal <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      r_retire <= 1'b0;
      case (r_state)
        S_FETCH: begin
          // the first cycle out of reset only raises req; gnt counts once req is visible
          if (r_req && imem_gnt) begin
            r_req   <= 1'b0;
            r_state <= S_WAIT;
          end else begin
            r_req <= 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            r_ir     <= imem_rdata;
            r_retire <= insn_legal(imem_rdata);
            r_state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_legal) begin
            if (r_ir[11:7] != 5'd0) begin
              r_regs[r_ir[7 +: AW]] <= w_result;
            end
            r_flags <= {w_result[XLEN-1], (w_result == '0), w_c, w_v};
            r_pc    <= r_pc + XLEN'(4);
            r_req   <= 1'b1;
            r_state <= S_FETCH;
          end else begin
            r_halt    <= 1'b1;
            r_illegal <= (r_ir != 32'h0000_0073);
            r_state   <= S_HALT;
          end
        end
        S_HALT: begin
          r_req <= 1'b0;
        end
        default: begin
          r_req     <= 1'b0;
          r_halt    <= 1'b1;
          r_illegal <= 1'b1;
          r_state   <= S_HALT;
        end
      endcase
    end
  end

  assign imem_req  = r_req;
  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign retire    = r_retire;
  assign flags     = r_flags;
  assign halt      = r_halt;
  assign illegal   = r_illegal;
  assign dbg_rdata = read_reg(dbg_raddr);

endmodule

// File: tb/tb_rv_alu_core_mc.sv
// Directed bench for rv_alu_core_mc: ALU results/flags, fetch stalls, halt paths,
// reset during a fetch, and an RV32E instance rejecting high register indices.
module tb_rv_alu_core_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic        retire;
  logic [3:0]  flags;
  logic        halt;
  logic        illegal;
  logic [4:0]  dbg_raddr;
  logic [31:0] dbg_rdata;

  logic        e_reset;
  logic        e_req;
  logic [31:0] e_addr;
  logic        e_gnt;
  logic        e_rvalid;
  logic [31:0] e_rdata;
  logic [31:0] e_pc;
  logic        e_retire;
  logic [3:0]  e_flags;
  logic        e_halt;
  logic        e_illegal;
  logic [4:0]  e_dbg_raddr;
  logic [31:0] e_dbg_rdata;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_ret = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (retire === 1'b1) n_ret <= n_ret + 1;
  end

  rv_alu_core_mc #(.XLEN(32), .NREGS(32), .RESET_PC(32'h0), .IMM_EN(1'b1)) u_dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pc(pc), .retire(retire), .flags(flags), .halt(halt), .illegal(illegal),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
  );

  rv_alu_core_mc #(.XLEN(32), .NREGS(16), .RESET_PC(32'h0), .IMM_EN(1'b1)) u_rv32e (
    .clk(clk), .reset(e_reset), .imem_req(e_req), .imem_addr(e_addr),
    .imem_gnt(e_gnt), .imem_rvalid(e_rvalid), .imem_rdata(e_rdata),
    .pc(e_pc), .retire(e_retire), .flags(e_flags), .halt(e_halt), .illegal(e_illegal),
    .dbg_raddr(e_dbg_raddr), .dbg_rdata(e_dbg_rdata)
  );

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  // Serve one fetch; returns at the negedge of the cycle after rvalid (EXEC)
  task automatic do_fetch(input logic [31:0] insn, input int gdly, input int rdly);
    int n;
    logic [31:0] a0;
    n = 0;
    while (imem_req !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    n_vec++;
    if (imem_req !== 1'b1) begin
      n_err++;
      $display("FAIL req_timeout: imem_req=%b required 1", imem_req);
    end
    a0 = imem_addr;
    for (int i = 0; i < gdly; i++) begin
      imem_gnt = 1'b0;
      @(negedge clk);
      n_vec++;
      if (imem_req !== 1'b1 || imem_addr !== a0) begin
        n_err++;
        $display("FAIL addr_stable: req=%b addr=%h required req=1 addr=%h", imem_req, imem_addr, a0);
      end
    end
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    for (int i = 1; i < rdly; i++) @(negedge clk);
    imem_rvalid = 1'b1;
    imem_rdata  = insn;
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hDEAD_BEEF;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    dbg_raddr = 5'd1;
    #1;
    n_vec++;
    if (pc !== 32'h0 || imem_req !== 1'b0 || retire !== 1'b0 || flags !== 4'h0 ||
        halt !== 1'b0 || illegal !== 1'b0 || dbg_rdata !== 32'h0) begin
      n_err++;
      $display("FAIL reset_state: pc=%h req=%b ret=%b fl=%b halt=%b ill=%b x1=%h required all 0",
               pc, imem_req, retire, flags, halt, illegal, dbg_rdata);
    end
  endtask

  task automatic test_alu_program();
    logic [31:0] ins [18];
    logic [4:0]  rd  [18];
    logic [31:0] val [18];
    logic [3:0]  fl  [18];
    int prev;
    ins[0]  = enc_i(12'd5, 5'd0, 3'b000, 5'd1);         rd[0]  = 5'd1;  val[0]  = 32'd5;         fl[0]  = 4'b0000;
    ins[1]  = enc_i(12'd3, 5'd0, 3'b000, 5'd2);         rd[1]  = 5'd2;  val[1]  = 32'd3;         fl[1]  = 4'b0000;
    ins[2]  = 32'h0020_81B3;                             rd[2]  = 5'd3;  val[2]  = 32'd8;         fl[2]  = 4'b0000;
    ins[3]  = enc_i(12'hFFF, 5'd0, 3'b000, 5'd1);       rd[3]  = 5'd1;  val[3]  = 32'hFFFF_FFFF; fl[3]  = 4'b1000;
    ins[4]  = enc_i(12'h001, 5'd1, 3'b101, 5'd1);       rd[4]  = 5'd1;  val[4]  = 32'h7FFF_FFFF; fl[4]  = 4'b0000;
    ins[5]  = enc_i(12'd1, 5'd0, 3'b000, 5'd2);         rd[5]  = 5'd2;  val[5]  = 32'd1;         fl[5]  = 4'b0000;
    ins[6]  = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);   rd[6]  = 5'd3;  val[6]  = 32'h8000_0000; fl[6]  = 4'b1001;
    ins[7]  = enc_r(7'h20, 5'd2, 5'd2, 3'b000, 5'd4);   rd[7]  = 5'd4;  val[7]  = 32'h0;         fl[7]  = 4'b0110;
    ins[8]  = enc_i(12'd1, 5'd0, 3'b000, 5'd1);         rd[8]  = 5'd1;  val[8]  = 32'd1;         fl[8]  = 4'b0000;
    ins[9]  = enc_i(12'h01F, 5'd1, 3'b001, 5'd1);       rd[9]  = 5'd1;  val[9]  = 32'h8000_0000; fl[9]  = 4'b1000;
    ins[10] = enc_i(12'h404, 5'd1, 3'b101, 5'd5);       rd[10] = 5'd5;  val[10] = 32'hF800_0000; fl[10] = 4'b1000;
    ins[11] = enc_i(12'h004, 5'd1, 3'b101, 5'd7);       rd[11] = 5'd7;  val[11] = 32'h0800_0000; fl[11] = 4'b0000;
    ins[12] = enc_r(7'h00, 5'd0, 5'd1, 3'b010, 5'd8);   rd[12] = 5'd8;  val[12] = 32'd1;         fl[12] = 4'b0000;
    ins[13] = enc_r(7'h00, 5'd0, 5'd1, 3'b011, 5'd9);   rd[13] = 5'd9;  val[13] = 32'd0;         fl[13] = 4'b0100;
    ins[14] = enc_i(12'd7, 5'd0, 3'b000, 5'd0);         rd[14] = 5'd0;  val[14] = 32'd0;         fl[14] = 4'b0000;
    ins[15] = enc_r(7'h00, 5'd2, 5'd1, 3'b100, 5'd10);  rd[15] = 5'd10; val[15] = 32'h8000_0001; fl[15] = 4'b1000;
    ins[16] = enc_r(7'h00, 5'd1, 5'd1, 3'b000, 5'd11);  rd[16] = 5'd11; val[16] = 32'h0;         fl[16] = 4'b0111;
    ins[17] = enc_r(7'h20, 5'd1, 5'd2, 3'b000, 5'd12);  rd[17] = 5'd12; val[17] = 32'h8000_0001; fl[17] = 4'b1001;
    reset = 1'b1;
    prev = cyc;
    for (int i = 0; i < 18; i++) begin
      do_fetch(ins[i], 0, 1);
      n_vec++;
      if (retire !== 1'b1 || (cyc - prev) !== 3) begin
        n_err++;
        $display("FAIL alu_retire[%0d]: retire=%b cycles=%0d required retire=1 cycles=3", i, retire, cyc - prev);
      end
      prev = cyc;
      @(negedge clk);
      dbg_raddr = rd[i];
      #1;
      n_vec++;
      if (dbg_rdata !== val[i] || flags !== fl[i] || pc !== 32'(4 * (i + 1)) || retire !== 1'b0) begin
        n_err++;
        $display("FAIL alu_result[%0d]: x%0d=%h fl=%b pc=%h ret=%b required %h %b %h 0",
                 i, rd[i], dbg_rdata, flags, pc, retire, val[i], fl[i], 32'(4 * (i + 1)));
      end
    end
  endtask

  task automatic test_stall();
    int t0;
    int r0;
    t0 = cyc - 1;
    r0 = n_ret;
    do_fetch(enc_i(12'd7, 5'd0, 3'b000, 5'd6), 4, 3);
    n_vec++;
    if (retire !== 1'b1 || (cyc - t0) !== 9) begin
      n_err++;
      $display("FAIL stall_cpi: retire=%b cycles=%0d required retire=1 cycles=9", retire, cyc - t0);
    end
    repeat (2) @(negedge clk);
    dbg_raddr = 5'd6;
    #1;
    n_vec++;
    if ((n_ret - r0) !== 1 || dbg_rdata !== 32'd7 || pc !== 32'h4C) begin
      n_err++;
      $display("FAIL stall_result: retires=%0d x6=%h pc=%h required 1 00000007 0000004c",
               n_ret - r0, dbg_rdata, pc);
    end
  endtask

  task automatic test_reset_in_wait();
    int r0;
    int n;
    n = 0;
    while (imem_req !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    r0 = n_ret;
    imem_rvalid = 1'b1;
    imem_rdata  = enc_i(12'd5, 5'd0, 3'b000, 5'd13);
    repeat (2) @(negedge clk);
    imem_rvalid = 1'b0;
    dbg_raddr = 5'd6;
    #1;
    n_vec++;
    if (n_ret !== r0 || imem_req !== 1'b1 || imem_addr !== 32'h0 || dbg_rdata !== 32'h0) begin
      n_err++;
      $display("FAIL stale_rvalid: retires=%0d req=%b addr=%h x6=%h required 0 1 00000000 00000000",
               n_ret - r0, imem_req, imem_addr, dbg_rdata);
    end
    do_fetch(enc_i(12'd9, 5'd0, 3'b000, 5'd14), 0, 1);
    @(negedge clk);
    dbg_raddr = 5'd14;
    #1;
    n_vec++;
    if (dbg_rdata !== 32'd9 || pc !== 32'h4 || (n_ret - r0) !== 1) begin
      n_err++;
      $display("FAIL refetch: x14=%h pc=%h retires=%0d required 00000009 00000004 1",
               dbg_rdata, pc, n_ret - r0);
    end
  endtask

  task automatic test_halt();
    logic [31:0] bad [6];
    logic        ill [6];
    int r0;
    logic req_seen;
    bad[0] = 32'h0000_0073;                           ill[0] = 1'b0;
    bad[1] = 32'h0000_0000;                           ill[1] = 1'b1;
    bad[2] = enc_r(7'h20, 5'd2, 5'd1, 3'b001, 5'd1);  ill[2] = 1'b1;
    bad[3] = enc_i(12'h401, 5'd1, 3'b001, 5'd1);      ill[3] = 1'b1;
    bad[4] = enc_r(7'h01, 5'd2, 5'd1, 3'b000, 5'd1);  ill[4] = 1'b1;
    bad[5] = enc_i(12'h201, 5'd1, 3'b101, 5'd1);      ill[5] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      do_fetch(enc_i(12'hFFF, 5'd0, 3'b000, 5'd1), 0, 1);
      do_fetch(bad[i], 0, 1);
      n_vec++;
      if (retire !== 1'b0) begin
        n_err++;
        $display("FAIL halt_retire[%0d]: retire=%b required 0", i, retire);
      end
      r0 = n_ret;
      req_seen = 1'b0;
      imem_gnt = 1'b1;
      imem_rvalid = 1'b1;
      repeat (5) begin
        @(negedge clk);
        if (imem_req !== 1'b0) req_seen = 1'b1;
      end
      imem_gnt = 1'b0;
      imem_rvalid = 1'b0;
      dbg_raddr = 5'd1;
      #1;
      n_vec++;
      if (halt !== 1'b1 || illegal !== ill[i] || pc !== 32'h4 || dbg_rdata !== 32'hFFFF_FFFF ||
          flags !== 4'b1000 || req_seen !== 1'b0 || n_ret !== r0) begin
        n_err++;
        $display("FAIL halt_state[%0d]: halt=%b ill=%b pc=%h x1=%h fl=%b req=%b ret=%0d required 1 %b 00000004 ffffffff 1000 0 0",
                 i, halt, illegal, pc, dbg_rdata, flags, req_seen, n_ret - r0, ill[i]);
      end
    end
  endtask

  task automatic test_rv32e();
    e_dbg_raddr = 5'd20;
    #1;
    n_vec++;
    if (e_halt !== 1'b1 || e_illegal !== 1'b1 || e_pc !== 32'h0 || e_dbg_rdata !== 32'h0) begin
      n_err++;
      $display("FAIL rv32e_rd20: halt=%b ill=%b pc=%h x20=%h required 1 1 00000000 00000000",
               e_halt, e_illegal, e_pc, e_dbg_rdata);
    end
  endtask

  initial begin
    reset       = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    dbg_raddr   = 5'd0;
    e_reset     = 1'b0;
    e_gnt       = 1'b1;
    e_rvalid    = 1'b1;
    e_rdata     = enc_i(12'd1, 5'd0, 3'b000, 5'd20);
    e_dbg_raddr = 5'd0;
    @(negedge clk);
    e_reset = 1'b1;
    test_reset();
    test_alu_program();
    test_stall();
    test_reset_in_wait();
    test_halt();
    test_rv32e();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
